// File: rtl/pic_pkg.sv
// Shared encodings for the 8259A-style command-register stage:
// write-target codes, init sequencer states and OCW2 command codes.
package pic_pkg;

  localparam logic [2:0] WR_ICW1 = 3'd0;
  localparam logic [2:0] WR_ICW2 = 3'd1;
  localparam logic [2:0] WR_ICW3 = 3'd2;
  localparam logic [2:0] WR_ICW4 = 3'd3;
  localparam logic [2:0] WR_OCW1 = 3'd4;
  localparam logic [2:0] WR_OCW2 = 3'd5;
  localparam logic [2:0] WR_OCW3 = 3'd6;

  typedef enum logic [2:0] {
    ST_UNINIT,
    ST_W_ICW2,
    ST_W_ICW3,
    ST_W_ICW4,
    ST_READY
  } init_state_t;

  typedef enum logic [2:0] {
    OCW2_CLR_RAEOI  = 3'b000,
    OCW2_NS_EOI     = 3'b001,
    OCW2_NOP        = 3'b010,
    OCW2_S_EOI      = 3'b011,
    OCW2_SET_RAEOI  = 3'b100,
    OCW2_ROT_NS_EOI = 3'b101,
    OCW2_SET_PRIO   = 3'b110,
    OCW2_ROT_S_EOI  = 3'b111
  } ocw2_cmd_t;

endpackage

// File: rtl/pic_init_fsm.sv
// Initialization sequencer: walks ICW1..ICW4 and issues one latch enable
// per accepted ICW; ICW1 restarts the sequence from any state.
module pic_init_fsm
  import pic_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        commit,
  input  logic [2:0]  wr_cur,
  input  logic        sngl,
  input  logic        icw4_exp,
  output init_state_t state,
  output logic        init_done,
  output logic        ld_icw1,
  output logic        ld_icw2,
  output logic        ld_icw3,
  output logic        ld_icw4
);

  init_state_t state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_UNINIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_icw1   = 1'b0;
    ld_icw2   = 1'b0;
    ld_icw3   = 1'b0;
    ld_icw4   = 1'b0;
    if (commit) begin
      if (wr_cur == WR_ICW1) begin
        ld_icw1   = 1'b1;
        state_nxt = ST_W_ICW2;
      end else begin
        unique case (state)
          ST_W_ICW2: if (wr_cur == WR_ICW2) begin
            ld_icw2   = 1'b1;
            state_nxt = !sngl ? ST_W_ICW3 : (icw4_exp ? ST_W_ICW4 : ST_READY);
          end
          ST_W_ICW3: if (wr_cur == WR_ICW3) begin
            ld_icw3   = 1'b1;
            state_nxt = icw4_exp ? ST_W_ICW4 : ST_READY;
          end
          ST_W_ICW4: if (wr_cur == WR_ICW4) begin
            ld_icw4   = 1'b1;
            state_nxt = ST_READY;
          end
          default: ;
        endcase
      end
    end
  end

  assign init_done = (state == ST_READY);

endmodule

// File: rtl/pic_command_registers.sv
// Clocked command-register stage: commits ICW/OCW writes, emits config
// levels and one-cycle command pulses, and drives registered read-back.
module pic_command_registers
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_flag,
  input  logic       rd_flag,
  input  logic       a0,
  input  logic [2:0] wr_cur,
  input  logic       no_icw4,
  input  logic [7:0] din,
  input  logic [7:0] irr,
  input  logic [7:0] isr,
  input  logic [7:0] poll_word,
  output logic       init_done,
  output logic [4:0] vector_base,
  output logic       ltim,
  output logic       sngl,
  output logic [7:0] cascade_cfg,
  output logic       upm,
  output logic       aeoi,
  output logic       ms,
  output logic       buf_mode,
  output logic       sfnm,
  output logic [7:0] imr,
  output logic       eoi_pulse,
  output logic       eoi_specific,
  output logic       rotate_pulse,
  output logic       set_prio_pulse,
  output logic [2:0] level,
  output logic       rotate_aeoi,
  output logic       smm,
  output logic [7:0] dout,
  output logic       dout_en
);

  logic        wr_q, rd_q, commit, rd_rise;
  logic        icw4_exp, rb_isr, poll_pending;
  logic        ld_icw1, ld_icw2, ld_icw3, ld_icw4;
  logic        ready, ocw1_wr, ocw2_wr, ocw3_wr;
  init_state_t init_state;
  ocw2_cmd_t   ocw2_cmd;

  assign commit   = wr_flag & ~wr_q;
  assign rd_rise  = rd_flag & ~rd_q;
  assign ready    = (init_state == ST_READY);
  assign ocw1_wr  = commit & ready & (wr_cur == WR_OCW1);
  assign ocw2_wr  = commit & ready & (wr_cur == WR_OCW2);
  assign ocw3_wr  = commit & ready & (wr_cur == WR_OCW3);
  assign ocw2_cmd = ocw2_cmd_t'(din[7:5]);

  pic_init_fsm u_init_fsm (
    .clk       (clk),
    .rst       (rst),
    .commit    (commit),
    .wr_cur    (wr_cur),
    .sngl      (sngl),
    .icw4_exp  (icw4_exp),
    .state     (init_state),
    .init_done (init_done),
    .ld_icw1   (ld_icw1),
    .ld_icw2   (ld_icw2),
    .ld_icw3   (ld_icw3),
    .ld_icw4   (ld_icw4)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q           <= 1'b0;
      rd_q           <= 1'b0;
      icw4_exp       <= 1'b0;
      rb_isr         <= 1'b0;
      poll_pending   <= 1'b0;
      vector_base    <= '0;
      ltim           <= 1'b0;
      sngl           <= 1'b0;
      cascade_cfg    <= '0;
      {sfnm, buf_mode, ms, aeoi, upm} <= '0;
      imr            <= '0;
      eoi_pulse      <= 1'b0;
      eoi_specific   <= 1'b0;
      rotate_pulse   <= 1'b0;
      set_prio_pulse <= 1'b0;
      level          <= '0;
      rotate_aeoi    <= 1'b0;
      smm            <= 1'b0;
      dout           <= '0;
      dout_en        <= 1'b0;
    end else begin
      wr_q           <= wr_flag;
      rd_q           <= rd_flag;
      eoi_pulse      <= 1'b0;
      eoi_specific   <= 1'b0;
      rotate_pulse   <= 1'b0;
      set_prio_pulse <= 1'b0;
      dout_en        <= rd_flag;

      // Read first so it samples pre-write state; a same-edge write that
      // sets or cancels a poll then overrides the read's poll clear.
      if (rd_rise) begin
        if (poll_pending) begin
          dout         <= poll_word;
          poll_pending <= 1'b0;
        end else if (a0) begin
          dout <= imr;
        end else begin
          dout <= rb_isr ? isr : irr;
        end
      end

      if (ld_icw1) begin
        ltim         <= din[3];
        sngl         <= din[1];
        icw4_exp     <= ~no_icw4;
        imr          <= '0;
        smm          <= 1'b0;
        rotate_aeoi  <= 1'b0;
        rb_isr       <= 1'b0;
        poll_pending <= 1'b0;
        if (no_icw4) {sfnm, buf_mode, ms, aeoi, upm} <= '0;
      end
      if (ld_icw2) vector_base <= din[7:3];
      if (ld_icw3) cascade_cfg <= din;
      if (ld_icw4) {sfnm, buf_mode, ms, aeoi, upm} <= din[4:0];

      if (ocw1_wr) imr <= din;

      if (ocw2_wr) begin
        level <= din[2:0];
        unique case (ocw2_cmd)
          OCW2_NS_EOI:     eoi_pulse <= 1'b1;
          OCW2_S_EOI:      {eoi_pulse, eoi_specific} <= 2'b11;
          OCW2_ROT_NS_EOI: {eoi_pulse, rotate_pulse} <= 2'b11;
          OCW2_ROT_S_EOI:  {eoi_pulse, eoi_specific, rotate_pulse} <= 3'b111;
          OCW2_SET_PRIO:   set_prio_pulse <= 1'b1;
          OCW2_SET_RAEOI:  rotate_aeoi <= 1'b1;
          OCW2_CLR_RAEOI:  rotate_aeoi <= 1'b0;
          default: ;
        endcase
      end

      if (ocw3_wr) begin
        if (din[6]) smm <= din[5];
        if (din[1]) rb_isr <= din[0];
        if (din[2]) poll_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pic_command_registers.sv
// Scoreboard bench: stimulus pushes expected read data and command pulses;
// monitors pop and compare when the DUT presents them.
module tb_pic_command_registers;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_flag = 1'b0, rd_flag = 1'b0, a0 = 1'b0, no_icw4 = 1'b0;
  logic [2:0] wr_cur = '0;
  logic [7:0] din = '0, irr = '0, isr = '0, poll_word = '0;
  logic       init_done, ltim, sngl, upm, aeoi, ms, buf_mode, sfnm;
  logic [4:0] vector_base;
  logic [7:0] cascade_cfg, imr, dout;
  logic       eoi_pulse, eoi_specific, rotate_pulse, set_prio_pulse;
  logic [2:0] level;
  logic       rotate_aeoi, smm, dout_en;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       e, s, r, p;
    logic [2:0] lv;
  } pulse_t;

  pulse_t     pq[$];
  logic [7:0] rq[$];
  logic       den_prev = 1'b0;

  always #5 clk = ~clk;

  pic_command_registers dut (
    .clk(clk), .rst(rst), .wr_flag(wr_flag), .rd_flag(rd_flag), .a0(a0),
    .wr_cur(wr_cur), .no_icw4(no_icw4), .din(din), .irr(irr), .isr(isr),
    .poll_word(poll_word), .init_done(init_done), .vector_base(vector_base),
    .ltim(ltim), .sngl(sngl), .cascade_cfg(cascade_cfg), .upm(upm),
    .aeoi(aeoi), .ms(ms), .buf_mode(buf_mode), .sfnm(sfnm), .imr(imr),
    .eoi_pulse(eoi_pulse), .eoi_specific(eoi_specific),
    .rotate_pulse(rotate_pulse), .set_prio_pulse(set_prio_pulse),
    .level(level), .rotate_aeoi(rotate_aeoi), .smm(smm), .dout(dout),
    .dout_en(dout_en)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {init_done, vector_base, ltim, sngl, cascade_cfg, upm, aeoi, ms,
            buf_mode, sfnm, imr, eoi_pulse, eoi_specific, rotate_pulse,
            set_prio_pulse, level, rotate_aeoi, smm, dout, dout_en};
  endfunction

  // Write pulse held two cycles: only the rising edge may commit.
  task automatic do_write(input logic [2:0] cur, input logic [7:0] data, input logic noi4);
    @(negedge clk);
    wr_flag = 1'b1; wr_cur = cur; din = data; no_icw4 = noi4;
    @(negedge clk);
    @(negedge clk);
    wr_flag = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_ocw2(input logic [7:0] data, input logic pulses);
    if (pulses) begin
      pulse_t p;
      p.e  = (data[5] == 1'b1) && (data[7:5] != 3'b100) && (data[7:5] != 3'b110) && (data[7:5] != 3'b010) ? 1'b1 : 1'b0;
      p.s  = (data[7:5] == 3'b011) || (data[7:5] == 3'b111);
      p.r  = (data[7:5] == 3'b101) || (data[7:5] == 3'b111);
      p.p  = (data[7:5] == 3'b110);
      p.lv = data[2:0];
      pq.push_back(p);
    end
    do_write(3'd5, data, 1'b0);
  endtask

  task automatic do_read(input logic addr, input logic [7:0] exp);
    rq.push_back(exp);
    @(negedge clk);
    rd_flag = 1'b1; a0 = addr;
    repeat (3) @(negedge clk);
    rd_flag = 1'b0;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (dout_en && !den_prev) begin
        if (rq.size() == 0) chk("read_unexpected", {56'd0, dout}, 64'hFFFF);
        else chk("read_data", {56'd0, dout}, {56'd0, rq.pop_front()});
      end
      if (eoi_pulse | eoi_specific | rotate_pulse | set_prio_pulse) begin
        if (pq.size() == 0)
          chk("pulse_unexpected", {eoi_pulse, eoi_specific, rotate_pulse, set_prio_pulse}, 64'd0);
        else
          chk("pulse_vec", {eoi_pulse, eoi_specific, rotate_pulse, set_prio_pulse, level},
              pq.pop_front());
      end
    end
    den_prev <= dout_en;
  end

  initial begin
    irr = 8'h22; isr = 8'h10; poll_word = 8'h83;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", all_outs(), 64'd0);

    do_write(3'd4, 8'hFF, 1'b0);
    chk("ocw1_before_init_imr", imr, 8'h00);

    do_write(3'd0, 8'h11, 1'b0);
    do_write(3'd1, 8'h40, 1'b0);
    chk("init_done_mid", init_done, 1'b0);
    do_write(3'd2, 8'h04, 1'b0);
    do_write(3'd3, 8'h03, 1'b0);
    chk("full_init_done", init_done, 1'b1);
    chk("full_vector_base", vector_base, 5'h08);
    chk("full_cascade", cascade_cfg, 8'h04);
    chk("full_icw4_fields", {sfnm, buf_mode, ms, aeoi, upm}, 5'b00011);
    chk("full_icw1_fields", {ltim, sngl}, 2'b00);

    do_ocw2(8'h63, 1'b1);
    do_ocw2(8'h80, 1'b0);
    chk("rotate_aeoi_set", rotate_aeoi, 1'b1);
    do_ocw2(8'hA5, 1'b1);
    do_ocw2(8'hC2, 1'b1);
    chk("level_hold", level, 3'd2);
    do_ocw2(8'h00, 1'b0);
    chk("rotate_aeoi_clr", rotate_aeoi, 1'b0);

    do_write(3'd4, 8'hA5, 1'b0);
    do_read(1'b1, 8'hA5);
    do_write(3'd6, 8'h0B, 1'b0);
    do_read(1'b0, 8'h10);
    do_write(3'd6, 8'h0A, 1'b0);
    do_read(1'b0, 8'h22);
    do_write(3'd6, 8'h0C, 1'b0);
    do_read(1'b0, 8'h83);
    do_read(1'b0, 8'h22);
    do_write(3'd6, 8'h68, 1'b0);
    chk("smm_set", smm, 1'b1);

    // Restart mid-init: partial sequence abandoned, then single/no-ICW4 init.
    do_write(3'd0, 8'h11, 1'b0);
    do_write(3'd1, 8'h48, 1'b0);
    do_write(3'd0, 8'h12, 1'b1);
    chk("restart_not_done", init_done, 1'b0);
    chk("restart_clears", {imr, smm, sngl}, {8'h00, 1'b0, 1'b1});
    chk("no_icw4_fields_zero", {sfnm, buf_mode, ms, aeoi, upm}, 5'b0);
    do_write(3'd2, 8'h99, 1'b0);
    chk("out_of_seq_icw3", cascade_cfg, 8'h04);
    do_write(3'd1, 8'h20, 1'b0);
    chk("single_done", init_done, 1'b1);
    chk("single_vector_base", vector_base, 5'h04);

    do_write(3'd0, 8'h11, 1'b0);
    do_write(3'd1, 8'h40, 1'b0);
    chk("w_icw3_not_done", init_done, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", all_outs(), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    do_write(3'd4, 8'h55, 1'b0);
    chk("post_reset_ocw1_ignored", {init_done, imr}, 9'd0);

    repeat (10) @(negedge clk);
    chk("pulse_queue_drained", pq.size(), 0);
    chk("read_queue_drained", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
